// File: rtl/ccff_cfg_pkg.sv
// ccff_cfg_pkg: shared state encoding, CRC-8 constants and word-count helper for the ccff chain loader
package ccff_cfg_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    function automatic int words_for(input int len, input int w);
        return (len + w - 1) / w;
    endfunction
endpackage

// File: rtl/ccff_crc8_serial.sv
// ccff_crc8_serial: one-bit-per-cycle MSB-first CRC-8 with synchronous clear and enable
module ccff_crc8_serial
    import ccff_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc,
    output logic [7:0] crc_nxt
);
    assign crc_nxt = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
    always_ff @(posedge clk)
        if (clr) crc <= CRC8_INIT;
        else if (en) crc <= crc_nxt;
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams config words MSB-first into a ccff chain; CCFF_LOADER_READBACK_EN adds CRC readback
module ccff_chain_loader
    import ccff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 26,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);
    localparam int WORDS = words_for(CHAIN_LEN, WORD_W);
    localparam int WC_W  = $clog2(WORDS + 1);
    localparam int REM_W = $clog2(WORD_W + 1);
    localparam int LAST  = CHAIN_LEN - (WORDS - 1) * WORD_W;
`ifdef CCFF_LOADER_READBACK_EN
    localparam state_t AFTER_LOAD = VERIFY;
`else
    localparam state_t AFTER_LOAD = FINISH;
`endif
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WC_W-1:0]   wcnt;
    logic [REM_W-1:0]  rem;
    logic [WORD_W-1:0] sr;
    logic              load, shift, accept, last_shift;
    assign load       = state == LOAD;
    assign busy       = load || state == VERIFY;
    assign done       = state == FINISH;
    assign cfg_ready  = load && rem <= REM_W'(1) && wcnt != WC_W'(WORDS);
    assign accept     = cfg_valid && cfg_ready;
    assign shift      = load && rem != '0;
    assign last_shift = shift && cnt == CNT_W'(CHAIN_LEN - 1);
`ifdef CCFF_LOADER_READBACK_EN
    logic [7:0] crc_w, crc_w_unused, crc_r_unused, crc_r_nxt;
    logic       verify, crc_clr;
    assign verify    = state == VERIFY;
    assign crc_clr   = !pReset || (state == IDLE && start);
    assign shift_en  = shift || verify;
    // recirculating the tail during VERIFY restores the loaded image
    assign ccff_head = load ? sr[WORD_W-1] : verify && ccff_tail;
    ccff_crc8_serial u_crc_w (
        .clk(prog_clk), .clr(crc_clr), .en(shift), .din(sr[WORD_W-1]),
        .crc(crc_w), .crc_nxt(crc_w_unused)
    );
    ccff_crc8_serial u_crc_r (
        .clk(prog_clk), .clr(crc_clr), .en(verify), .din(ccff_tail),
        .crc(crc_r_unused), .crc_nxt(crc_r_nxt)
    );
    always_ff @(posedge prog_clk)
        if (crc_clr) crc_err <= 1'b0;
        else if (verify && !abort && cnt == CNT_W'(CHAIN_LEN - 1)) crc_err <= crc_w != crc_r_nxt;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign shift_en    = shift;
    assign ccff_head   = load && sr[WORD_W-1];
    assign crc_err     = 1'b0;
`endif
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state <= IDLE;
            cnt   <= '0;
            wcnt  <= '0;
            rem   <= '0;
            sr    <= '0;
        end else begin
            // the final word only contributes its upper LAST bits
            if (accept) begin
                sr   <= cfg_data;
                rem  <= (wcnt == WC_W'(WORDS - 1)) ? REM_W'(LAST) : REM_W'(WORD_W);
                wcnt <= wcnt + 1'b1;
            end else if (shift) begin
                sr  <= sr << 1;
                rem <= rem - 1'b1;
            end
            unique case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    cnt   <= '0;
                    wcnt  <= '0;
                    rem   <= '0;
                end
                LOAD: begin
                    cnt <= cnt + CNT_W'(shift);
                    if (abort) begin
                        state <= IDLE;
                        rem   <= '0;
                    end else if (last_shift) begin
                        state <= AFTER_LOAD;
                        cnt   <= '0;
                    end
                end
                VERIFY: begin
                    cnt <= cnt + 1'b1;
                    if (abort) state <= IDLE;
                    else if (cnt == CNT_W'(CHAIN_LEN - 1)) state <= FINISH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: vector table plus scoreboard of expected ccff_head bits against chain models
module tb_ccff_chain_loader;
    localparam int CL = 26;
`ifdef CCFF_LOADER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    logic prog_clk = 0, pReset = 0, start = 0, abort = 0, cfg_valid = 0;
    logic [7:0] cfg_data = '0;
    logic cfg_ready, ccff_head, ccff_tail, shift_en, busy, done, crc_err;
    logic [CL-1:0] chain = '0;
    bit stuck = 0;
    logic s8 = 0, v8 = 0, rdy8, h8, t8, se8, b8, dn8, ce8;
    logic [7:0] d8 = '0, chain8 = '0;
    logic s1 = 0, v1 = 0, rdy1, h1, t1, se1, b1, dn1, ce1;
    logic [7:0] d1 = '0;
    logic chain1 = 0;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .shift_en(shift_en),
        .busy(busy), .done(done), .crc_err(crc_err)
    );
    ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
        .prog_clk(prog_clk), .pReset(pReset), .start(s8), .abort(1'b0),
        .cfg_data(d8), .cfg_valid(v8), .cfg_ready(rdy8),
        .ccff_head(h8), .ccff_tail(t8), .shift_en(se8),
        .busy(b8), .done(dn8), .crc_err(ce8)
    );
    ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(8)) dut1 (
        .prog_clk(prog_clk), .pReset(pReset), .start(s1), .abort(1'b0),
        .cfg_data(d1), .cfg_valid(v1), .cfg_ready(rdy1),
        .ccff_head(h1), .ccff_tail(t1), .shift_en(se1),
        .busy(b1), .done(dn1), .crc_err(ce1)
    );

    always #5 prog_clk = ~prog_clk;

    // chain models: one flop per config bit, optional stuck-at-0 at bit 12
    assign ccff_tail = chain[CL-1];
    assign t8 = chain8[7];
    assign t1 = chain1;
    always @(posedge prog_clk) begin
        if (shift_en) chain <= {chain[CL-2:0], ccff_head} & ~(stuck ? (CL'(1) << 12) : CL'(0));
        if (se8) chain8 <= {chain8[6:0], h8};
        if (se1) chain1 <= h1;
    end

    typedef struct {
        string       name;
        logic [31:0] d;
        int          gap;
        int          abort_at;
        int          exp_shift;
        int          exp_gap;
        int          exp_done;
    } vec_t;

    int tests = 0, fails = 0;
    logic q[$];
    int nshift, nver, ndone, ngap, nacc, npush, nlate;
    bit busy_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        nshift = 0; nver = 0; ndone = 0; ngap = 0; nacc = 0; npush = 0; nlate = 0;
        busy_done = 1;
        q.delete();
    endtask

    // sample at negedge, scoreboard head bits, then step past the next rising edge
    task automatic cycle();
        int e;
        @(negedge prog_clk);
        if (shift_en) begin
            if (nshift < CL) begin
                e = (q.size() != 0) ? int'(q.pop_front()) : 2;
                chk("head", 32'(ccff_head), e);
                nshift++;
            end else begin
                chk("recirc", 32'(ccff_head), 32'(ccff_tail));
                nver++;
            end
        end
        if (busy && !shift_en && nshift > 0 && nshift < CL) ngap++;
        if (done) begin
            ndone++;
            busy_done = busy;
        end
        if (cfg_ready && npush >= CL) nlate++;
        if (cfg_valid && cfg_ready) begin
            nacc++;
            for (int i = 7; i >= 0 && npush < CL; i--) begin
                q.push_back(cfg_data[i]);
                npush++;
            end
        end
        @(posedge prog_clk);
        #1;
    endtask

    task automatic run_load(input logic [31:0] d, input int gap, input int abort_at);
        logic [31:0] dd;
        int hold, prev;
        clear_counts();
        hold = 0;
        start = 1;
        cycle();
        start = 0;
        for (int c = 0; c < 200 && ndone == 0; c++) begin
            dd = d << (8 * nacc);
            cfg_valid = nacc < 4 && hold == 0;
            cfg_data = dd[31:24];
            abort = abort_at >= 0 && nshift == abort_at - 1;
            prev = nacc;
            cycle();
            if (prev == 1 && nacc == 2) hold = gap;
            else if (hold > 0) hold--;
            if (abort) begin
                abort = 0;
                break;
            end
        end
        cfg_valid = 0;
    endtask

    task automatic run_b1(input logic [7:0] w);
        int n, nd, acc, late;
        n = 0; nd = 0; acc = 0; late = 0;
        s1 = 1;
        @(posedge prog_clk); #1;
        s1 = 0; v1 = 1; d1 = w;
        for (int c = 0; c < 40 && nd == 0; c++) begin
            @(negedge prog_clk);
            if (se1) begin
                if (n == 0) chk("b1_head", 32'(h1), 32'(w[7]));
                n++;
            end
            if (rdy1 && acc > 0) late++;
            if (v1 && rdy1) acc++;
            if (dn1) nd++;
            @(posedge prog_clk); #1;
            if (acc > 0) v1 = 0;
        end
        chk("b1_shifts", n, 1 + RB);
        chk("b1_done", nd, 1);
        chk("b1_image", 32'(chain1), 32'(w[7]));
        chk("b1_ready_late", late, 0);
    endtask

    initial begin
        vec_t tv[4];
        int n, nd, acc;
        tv[0] = '{"stream", 32'hA53CF0C0, 0, -1, 26, 0, 1};
        tv[1] = '{"starve", 32'hA53CF0C0, 12, -1, 26, 5, 1};
        tv[2] = '{"abort", 32'hA53CF0C0, 0, 10, 10, 0, 0};
        tv[3] = '{"reload", 32'h5AC30F40, 0, -1, 26, 0, 1};
        repeat (3) @(posedge prog_clk);
        #1;
        chk("reset_outputs", {cfg_ready, shift_en, ccff_head, busy, done, crc_err}, 6'b0);
        chk("reset_outputs8", {rdy8, se8, h8, b8, dn8, ce8}, 6'b0);
        pReset = 1;
        abort = 1;
        @(posedge prog_clk); #1;
        abort = 0;
        chk("abort_in_idle", {busy, done, cfg_ready}, 3'b0);

        for (int t = 0; t < 4; t++) begin
            run_load(tv[t].d, tv[t].gap, tv[t].abort_at);
            if (tv[t].abort_at >= 0) chk({tv[t].name, "_idle"}, {busy, cfg_ready, done}, 3'b0);
            cycle();
            cycle();
            chk({tv[t].name, "_shifts"}, nshift, tv[t].exp_shift);
            chk({tv[t].name, "_done"}, ndone, tv[t].exp_done);
            chk({tv[t].name, "_gap"}, ngap, tv[t].exp_gap);
            if (tv[t].exp_done != 0) begin
                chk({tv[t].name, "_busy_at_done"}, 32'(busy_done), 0);
                chk({tv[t].name, "_image"}, 32'(chain), 32'(tv[t].d[31:6]));
                chk({tv[t].name, "_ready_late"}, nlate, 0);
                chk({tv[t].name, "_words"}, nacc, 4);
                chk({tv[t].name, "_verify"}, nver, RB * CL);
                chk({tv[t].name, "_crc_err"}, 32'(crc_err), 0);
            end
        end

        // reset after the first word, then a clean full load
        start = 1;
        @(posedge prog_clk); #1;
        start = 0; cfg_valid = 1; cfg_data = 8'hA5;
        @(posedge prog_clk); #1;
        cfg_valid = 0;
        @(posedge prog_clk); #1;
        pReset = 0;
        @(posedge prog_clk); #1;
        chk("midreset_outputs", {cfg_ready, shift_en, ccff_head, busy, done, crc_err}, 6'b0);
        pReset = 1;
        run_load(32'hA53CF0C0, 0, -1);
        cycle();
        chk("after_reset_shifts", nshift, CL);
        chk("after_reset_done", ndone, 1);
        chk("after_reset_image", 32'(chain), 32'(26'h294F3C3));

`ifdef CCFF_LOADER_READBACK_EN
        stuck = 1;
        run_load(32'hFFFFFFFF, 0, -1);
        cycle();
        chk("stuck_done", ndone, 1);
        chk("stuck_crc_err", 32'(crc_err), 1);
        stuck = 0;
        start = 1;
        @(posedge prog_clk); #1;
        start = 0;
        chk("crc_err_clear_on_start", 32'(crc_err), 0);
        abort = 1;
        @(posedge prog_clk); #1;
        abort = 0;
`endif

        n = 0; nd = 0; acc = 0;
        s8 = 1;
        @(posedge prog_clk); #1;
        s8 = 0; v8 = 1; d8 = 8'hB4;
        for (int c = 0; c < 60 && nd == 0; c++) begin
            @(negedge prog_clk);
            if (se8) begin
                if (n < 8) chk("b8_head", 32'(h8), 32'(d8[7 - n]));
                n++;
            end
            if (v8 && rdy8) acc++;
            if (dn8) nd++;
            @(posedge prog_clk); #1;
            if (acc > 0) v8 = 0;
        end
        chk("b8_shifts", n, 8 * (1 + RB));
        chk("b8_done", nd, 1);
        chk("b8_image", 32'(chain8), 32'hB4);
        chk("b8_crc_err", 32'(ce8), 0);
        run_b1(8'h80);
        run_b1(8'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
